// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, the FSM state type and the digit-count helper
// used by the binary-to-BCD converter.
//   BCD_NIBBLE_W   - width of one BCD digit
//   ADD3_THRESHOLD - a digit at or above this value gets +3 before each shift
//   min_bcd_digits - number of decimal digits needed for 2^bin_w - 1
package bcd_pkg;

  localparam int BCD_NIBBLE_W = 4;
  localparam logic [BCD_NIBBLE_W-1:0] ADD3_THRESHOLD = 4'd5;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // Counts the decimal digits of the largest unsigned value that fits in bin_w bits.
  function automatic int min_bcd_digits(input int bin_w);
    longint unsigned max_val;
    int digits;
    max_val = (64'd1 << bin_w) - 64'd1;
    digits = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      digits++;
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: the combinational add-3 correction for a single BCD digit.
// Ports:
//   digit    - current scratch digit
//   adjusted - digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] digit,
  output logic [BCD_NIBBLE_W-1:0] adjusted
);

  // The sum stays inside the nibble; a legal digit (<= 9) never exceeds 12 after adjust.
  assign adjusted = (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: iterative double-dabble binary-to-BCD converter.
// One bit of the operand is consumed per clock, so a conversion takes BIN_W
// cycles after the accept edge.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - A holds a value to convert
//   in_ready  - converter is idle and can accept A
//   A         - unsigned binary operand (BIN_W bits)
//   out_valid - one-cycle pulse, B holds a new result
//   B         - packed BCD result, digit i in B[4i+3:4i]
//   busy      - conversion in progress
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 4,
  parameter int DIGITS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIN_W-1:0]               A,
  output logic                           out_valid,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] B,
  output logic                           busy
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Too few digits would silently drop the top of large results, so refuse to build.
  if (DIGITS < min_bcd_digits(BIN_W)) begin : g_digits_check
    $error("bin_to_bcd: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, BIN_W);
  end

  conv_state_t state, next_state;

  logic [CNT_W-1:0]       count;
  logic [BIN_W-1:0]       bin_sr;
  logic [BCD_W-1:0]       scratch;
  logic [BCD_W-1:0]       scratch_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   accept;
  logic                   last_iter;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign accept    = in_valid && in_ready;
  assign last_iter = (state == CONV) && (count == CNT_W'(1));

  for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .adjusted (scratch_adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Adjust first, then shift the combined register so the next binary MSB enters digit 0.
  assign shifted = {scratch_adj, bin_sr} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CONV;
      CONV:    if (last_iter) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // B is written only on the final iteration, so intermediate scratch values never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      bin_sr    <= '0;
      scratch   <= '0;
      B         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        bin_sr  <= A;
        scratch <= '0;
        count   <= CNT_W'(BIN_W);
      end else if (state == CONV) begin
        scratch <= shifted[BIN_W +: BCD_W];
        bin_sr  <= shifted[BIN_W-1:0];
        count   <= count - CNT_W'(1);
        if (last_iter) begin
          B         <= shifted[BIN_W +: BCD_W];
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: scoreboard bench for bin_to_bcd in the default 4-bit/2-digit
// configuration and in an 8-bit/3-digit configuration.
// Stimulus pushes the expected BCD value and the cycle at which out_valid must
// appear; one monitor per instance pops and compares when out_valid pulses.
module tb_bin_to_bcd;

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        in_valid4, in_ready4, out_valid4, busy4;
  logic [3:0]  A4;
  logic [7:0]  B4;
  logic        in_valid8, in_ready8, out_valid8, busy8;
  logic [7:0]  A8;
  logic [11:0] B8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  logic [7:0]  last_b4;
  logic [11:0] last_b8;
  logic        prev_ov4, prev_ov8;

  bin_to_bcd #(.BIN_W(4), .DIGITS(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A4), .out_valid(out_valid4), .B(B4), .busy(busy4)
  );

  bin_to_bcd #(.BIN_W(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .out_valid(out_valid8), .B(B8), .busy(busy8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Called at a negedge: waits (bounded) for the converter to be idle, then offers a for one cycle.
  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] exp_b);
    int waited = 0;
    while (!in_ready4 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready4_before_accept", {31'b0, in_ready4}, 32'd1);
    A4 = a;
    in_valid4 = 1'b1;
    q4.push_back('{bcd: {4'h0, exp_b}, due: cyc + 5});
    @(negedge clk);
    in_valid4 = 1'b0;
    A4 = ~a;
    checkOutput("busy4_after_accept", {31'b0, busy4}, 32'd1);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [11:0] exp_b);
    int waited = 0;
    while (!in_ready8 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready8_before_accept", {31'b0, in_ready8}, 32'd1);
    A8 = a;
    in_valid8 = 1'b1;
    q8.push_back('{bcd: exp_b, due: cyc + 9});
    @(negedge clk);
    in_valid8 = 1'b0;
    A8 = ~a;
  endtask

  task automatic waitIdle4();
    int n = 0;
    while ((q4.size() != 0 || !in_ready4) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_b4 = 8'h00;
      prev_ov4 = 1'b0;
    end else begin
      if (out_valid4) begin
        checkOutput("in_ready4_with_out_valid", {31'b0, in_ready4}, 32'd1);
        checkOutput("out_valid4_one_cycle", {31'b0, prev_ov4}, 32'd0);
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out_valid4: got B=0x%0h, required no result (cycle %0d)", B4, cyc);
        end else begin
          e4 = q4.pop_front();
          checkOutput("B4_result", {24'b0, B4}, {24'b0, e4.bcd[7:0]});
          checkOutput("B4_latency_cycle", cyc, e4.due);
          last_b4 = e4.bcd[7:0];
        end
      end else begin
        checkOutput("B4_hold", {24'b0, B4}, {24'b0, last_b4});
        if (q4.size() != 0 && q4[0].due < cyc) begin
          e4 = q4.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL B4_timeout: got no out_valid, required 0x%0h by cycle %0d", e4.bcd[7:0], e4.due);
        end
      end
      prev_ov4 = out_valid4;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last_b8 = 12'h000;
      prev_ov8 = 1'b0;
    end else begin
      if (out_valid8) begin
        checkOutput("out_valid8_one_cycle", {31'b0, prev_ov8}, 32'd0);
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out_valid8: got B=0x%0h, required no result (cycle %0d)", B8, cyc);
        end else begin
          e8 = q8.pop_front();
          checkOutput("B8_result", {20'b0, B8}, {20'b0, e8.bcd});
          checkOutput("B8_latency_cycle", cyc, e8.due);
          last_b8 = e8.bcd;
        end
      end else begin
        checkOutput("B8_hold", {20'b0, B8}, {20'b0, last_b8});
        if (q8.size() != 0 && q8[0].due < cyc) begin
          e8 = q8.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL B8_timeout: got no out_valid, required 0x%0h by cycle %0d", e8.bcd, e8.due);
        end
      end
      prev_ov8 = out_valid8;
    end
  end

  // Values held on A while in_valid stays high; accepts land on indices 0, 5 and 10
  // (four conversion cycles plus the idle cycle in which out_valid pulses).
  logic [3:0] cont_a [15] = '{4'd7, 4'd1, 4'd2, 4'd3, 4'd4,
                              4'd14, 4'd6, 4'd6, 4'd6, 4'd6,
                              4'd11, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [7:0] cont_exp [3] = '{8'h07, 8'h14, 8'h11};
  logic [3:0] dir_a [7] = '{4'd3, 4'd10, 4'd15, 4'd0, 4'd8, 4'd12, 4'd13};
  logic [7:0] dir_exp [7] = '{8'h03, 8'h10, 8'h15, 8'h00, 8'h08, 8'h12, 8'h13};

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0;
    A4 = 4'h0;
    in_valid8 = 1'b0;
    A8 = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_B4", {24'b0, B4}, 32'h0);
    checkOutput("reset_out_valid4", {31'b0, out_valid4}, 32'd0);
    checkOutput("reset_in_ready4", {31'b0, in_ready4}, 32'd1);
    checkOutput("reset_busy4", {31'b0, busy4}, 32'd0);
    checkOutput("reset_B8", {20'b0, B8}, 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(dir_a[i], dir_exp[i]);

    // Second accept lands in the out_valid cycle of the first.
    applyStimulus(4'd12, 8'h12);
    applyStimulus(4'd5, 8'h05);

    waitIdle4();
    for (int i = 0; i < 15; i++) begin
      A4 = cont_a[i];
      in_valid4 = 1'b1;
      if (i % 5 == 0) q4.push_back('{bcd: {4'h0, cont_exp[i / 5]}, due: cyc + 5});
      @(negedge clk);
    end
    in_valid4 = 1'b0;

    // Reset two cycles into a conversion of 15 must abort it without any result.
    waitIdle4();
    A4 = 4'd15;
    in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_B4", {24'b0, B4}, 32'h0);
    checkOutput("abort_out_valid4", {31'b0, out_valid4}, 32'd0);
    checkOutput("abort_in_ready4", {31'b0, in_ready4}, 32'd1);
    checkOutput("abort_busy4", {31'b0, busy4}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("after_abort_in_ready4", {31'b0, in_ready4}, 32'd1);
    applyStimulus(4'd9, 8'h09);
    waitIdle4();

    applyStimulus8(8'd255, 12'h255);
    applyStimulus8(8'd100, 12'h100);
    applyStimulus8(8'd99, 12'h099);
    for (int v = 0; v < 256; v++) applyStimulus8(8'(v), ref_bcd(v));

    repeat (15) @(negedge clk);
    checkOutput("q4_drained", q4.size(), 32'd0);
    checkOutput("q8_drained", q8.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
